// File: rtl/fb_triple_buffer_ctrl.sv
// Triple-buffer scheduler for the frame store shared by the capture writer
// and the scan-out reader. Three buffer indices (writer W, reader R, latest
// L) are always a permutation of {0,1,2}; the writer swaps W<->L when it
// completes a frame, and the reader swaps R<->L at its frame start when a
// newer complete frame is waiting. Base addresses, status and the
// drop/repeat statistics are all registered.
module fb_triple_buffer_ctrl #(
   parameter int unsigned           ADDR_W      = 32,
   parameter int unsigned           CNT_W       = 16,
   parameter logic [ADDR_W-1:0]     BASE_ADDR   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0]     FRAME_BYTES = 32'h0040_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear_counts,
   input  logic              wr_frame_start,
   input  logic              wr_frame_done,
   input  logic              rd_frame_start,
   output logic [ADDR_W-1:0] wr_base,
   output logic [ADDR_W-1:0] rd_base,
   output logic [1:0]        wr_idx,
   output logic [1:0]        rd_idx,
   output logic [1:0]        lat_idx,
   output logic              latest_valid,
   output logic              irq_new_frame,
   output logic              wr_seq_err,
   output logic [CNT_W-1:0]  drop_count,
   output logic [CNT_W-1:0]  repeat_count
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } wr_state_t;

   // Byte address of buffer idx; arithmetic wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
      logic [ADDR_W-1:0] b;
      case (idx)
         2'd0:    b = BASE_ADDR;
         2'd1:    b = BASE_ADDR + FRAME_BYTES;
         2'd2:    b = BASE_ADDR + {FRAME_BYTES[ADDR_W-2:0], 1'b0};
         default: b = BASE_ADDR;
      endcase
      return b;
   endfunction

   // Saturating counter step with clear taking priority over increment.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic clr,
                                                 input logic inc);
      logic [CNT_W-1:0] n;
      if (clr) begin
         n = {CNT_W{1'b0}};
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         n = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         n = cnt;
      end
      return n;
   endfunction

   wr_state_t         state_r;
   wr_state_t         state_nxt_s;
   logic [1:0]        w_r, r_r, l_r;
   logic [1:0]        w_nxt_s, r_nxt_s, l_nxt_s, l_mid_s;
   logic              new_flag_r;
   logic              flag_mid_s, flag_nxt_s;
   logic              accept_s, seq_ev_s, drop_inc_s, rep_inc_s;
   logic              latest_valid_r, irq_r, seq_err_r;
   logic [CNT_W-1:0]  drop_r, repeat_r;
   logic [ADDR_W-1:0] wr_base_r, rd_base_r;

   // Decode writer/reader events and derive the next index permutation;
   // the writer swap is applied before the reader swap in the same cycle.
   always_comb begin
      accept_s    = 1'b0;
      seq_ev_s    = 1'b0;
      state_nxt_s = state_r;
      if (!enable) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (wr_frame_done) begin
                  seq_ev_s = 1'b1;
               end else begin
                  seq_ev_s = 1'b0;
               end
               if (wr_frame_start) begin
                  state_nxt_s = ST_ACTIVE;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               if (wr_frame_done) begin
                  accept_s    = 1'b1;
                  state_nxt_s = wr_frame_start ? ST_ACTIVE : ST_IDLE;
               end else if (wr_frame_start) begin
                  seq_ev_s    = 1'b1;
                  state_nxt_s = ST_ACTIVE;
               end else begin
                  state_nxt_s = ST_ACTIVE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end

      // Writer stage: hand the completed buffer over as latest.
      if (accept_s) begin
         w_nxt_s    = l_r;
         l_mid_s    = w_r;
         flag_mid_s = 1'b1;
      end else begin
         w_nxt_s    = w_r;
         l_mid_s    = l_r;
         flag_mid_s = new_flag_r;
      end
      drop_inc_s = accept_s & new_flag_r;

      // Reader stage: take the newest frame if one is pending, else repeat.
      r_nxt_s    = r_r;
      l_nxt_s    = l_mid_s;
      flag_nxt_s = flag_mid_s;
      rep_inc_s  = 1'b0;
      if (enable && rd_frame_start) begin
         if (flag_mid_s) begin
            r_nxt_s    = l_mid_s;
            l_nxt_s    = r_r;
            flag_nxt_s = 1'b0;
         end else begin
            rep_inc_s  = 1'b1;
         end
      end else begin
         rep_inc_s  = 1'b0;
      end
   end

   // Writer FSM, buffer rotation and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         w_r            <= 2'd0;
         r_r            <= 2'd1;
         l_r            <= 2'd2;
         new_flag_r     <= 1'b0;
         latest_valid_r <= 1'b0;
         irq_r          <= 1'b0;
         seq_err_r      <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         w_r            <= w_nxt_s;
         r_r            <= r_nxt_s;
         l_r            <= l_nxt_s;
         new_flag_r     <= flag_nxt_s;
         latest_valid_r <= latest_valid_r | accept_s;
         irq_r          <= accept_s;
         seq_err_r      <= seq_err_r | seq_ev_s;
      end
   end

   // Saturating drop/repeat statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_r   <= {CNT_W{1'b0}};
         repeat_r <= {CNT_W{1'b0}};
      end else begin
         drop_r   <= cnt_next(drop_r, clear_counts, drop_inc_s);
         repeat_r <= cnt_next(repeat_r, clear_counts, rep_inc_s);
      end
   end

   // Base addresses follow their index one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_base_r <= base_of(2'd0);
         rd_base_r <= base_of(2'd1);
      end else begin
         wr_base_r <= base_of(w_r);
         rd_base_r <= base_of(r_r);
      end
   end

   assign wr_base       = wr_base_r;
   assign rd_base       = rd_base_r;
   assign wr_idx        = w_r;
   assign rd_idx        = r_r;
   assign lat_idx       = l_r;
   assign latest_valid  = latest_valid_r;
   assign irq_new_frame = irq_r;
   assign wr_seq_err    = seq_err_r;
   assign drop_count    = drop_r;
   assign repeat_count  = repeat_r;

endmodule

// File: tb/tb_fb_triple_buffer_ctrl.sv
// Directed self-checking bench for fb_triple_buffer_ctrl with hand-computed
// expectations (default parameters: buffers at 0x0, 0x40_0000, 0x80_0000).
module tb_fb_triple_buffer_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        clear_counts;
   logic        wr_frame_start;
   logic        wr_frame_done;
   logic        rd_frame_start;
   logic [31:0] wr_base;
   logic [31:0] rd_base;
   logic [1:0]  wr_idx, rd_idx, lat_idx;
   logic        latest_valid;
   logic        irq_new_frame;
   logic        wr_seq_err;
   logic [15:0] drop_count;
   logic [15:0] repeat_count;

   int err_cnt = 0;
   int chk_cnt = 0;

   fb_triple_buffer_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .clear_counts   (clear_counts),
      .wr_frame_start (wr_frame_start),
      .wr_frame_done  (wr_frame_done),
      .rd_frame_start (rd_frame_start),
      .wr_base        (wr_base),
      .rd_base        (rd_base),
      .wr_idx         (wr_idx),
      .rd_idx         (rd_idx),
      .lat_idx        (lat_idx),
      .latest_valid   (latest_valid),
      .irq_new_frame  (irq_new_frame),
      .wr_seq_err     (wr_seq_err),
      .drop_count     (drop_count),
      .repeat_count   (repeat_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      enable         = 1'b1;
      clear_counts   = 1'b0;
      wr_frame_start = 1'b0;
      wr_frame_done  = 1'b0;
      rd_frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic chk_idx(input string tag, input logic [1:0] w, input logic [1:0] r, input logic [1:0] l);
      check_eq({tag, "_w"}, 32'(wr_idx), 32'(w));
      check_eq({tag, "_r"}, 32'(rd_idx), 32'(r));
      check_eq({tag, "_l"}, 32'(lat_idx), 32'(l));
   endtask

   task automatic chk_perm(input string tag);
      logic [3:0] m;
      m = (4'b0001 << wr_idx) | (4'b0001 << rd_idx) | (4'b0001 << lat_idx);
      check_eq(tag, 32'(m[2:0]), 32'h7);
   endtask

   task automatic wr_frame();
      wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
      wr_frame_done  = 1'b1; step(); wr_frame_done  = 1'b0;
   endtask

   initial begin
      // 1. reset state, one written frame, then reader picks it up
      do_reset();
      chk_idx("rst", 2'd0, 2'd1, 2'd2);
      check_eq("rst_wr_base", wr_base, 32'h0000_0000);
      check_eq("rst_rd_base", rd_base, 32'h0040_0000);
      check_eq("rst_latest", 32'(latest_valid), 32'h0);
      check_eq("rst_irq", 32'(irq_new_frame), 32'h0);
      check_eq("rst_seq", 32'(wr_seq_err), 32'h0);
      check_eq("rst_drop", 32'(drop_count), 32'h0);
      check_eq("rst_rep", 32'(repeat_count), 32'h0);
      wr_frame();
      chk_idx("t1_done", 2'd2, 2'd1, 2'd0);
      check_eq("t1_irq_hi", 32'(irq_new_frame), 32'h1);
      check_eq("t1_latest", 32'(latest_valid), 32'h1);
      check_eq("t1_wr_base_lag", wr_base, 32'h0000_0000);
      step();
      check_eq("t1_irq_lo", 32'(irq_new_frame), 32'h0);
      check_eq("t1_wr_base", wr_base, 32'h0080_0000);
      rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
      chk_idx("t1_rd", 2'd2, 2'd0, 2'd1);
      step();
      check_eq("t1_rd_base", rd_base, 32'h0000_0000);
      check_eq("t1_wr_base2", wr_base, 32'h0080_0000);
      check_eq("t1_rep", 32'(repeat_count), 32'h0);

      // 2. three frames without reader -> two drops
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_frame();
         check_eq("t2_r_fixed", 32'(rd_idx), 32'h1);
         chk_perm("t2_perm");
      end
      chk_idx("t2_end", 2'd2, 2'd1, 2'd0);
      check_eq("t2_drop", 32'(drop_count), 32'h2);

      // 3. reader starts before any frame -> repeats
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
         step();
      end
      check_eq("t3_rep", 32'(repeat_count), 32'h4);
      check_eq("t3_r", 32'(rd_idx), 32'h1);
      check_eq("t3_latest", 32'(latest_valid), 32'h0);

      // 4. accepted done coincident with reader start
      do_reset();
      wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
      wr_frame_done = 1'b1; rd_frame_start = 1'b1; step();
      wr_frame_done = 1'b0; rd_frame_start = 1'b0;
      chk_idx("t4", 2'd2, 2'd0, 2'd1);
      check_eq("t4_drop", 32'(drop_count), 32'h0);
      check_eq("t4_rep", 32'(repeat_count), 32'h0);
      rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
      check_eq("t4_flag_clear", 32'(repeat_count), 32'h1);
      check_eq("t4_r_hold", 32'(rd_idx), 32'h0);

      // 5a. done while idle
      do_reset();
      wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
      check_eq("t5_idle_done_err", 32'(wr_seq_err), 32'h1);
      chk_idx("t5_idle_done", 2'd0, 2'd1, 2'd2);
      // 5b. double start, then done still accepted
      do_reset();
      wr_frame_start = 1'b1; step(); step(); wr_frame_start = 1'b0;
      check_eq("t5_dbl_err", 32'(wr_seq_err), 32'h1);
      chk_idx("t5_dbl", 2'd0, 2'd1, 2'd2);
      wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
      chk_idx("t5_dbl_done", 2'd2, 2'd1, 2'd0);
      // 5c. disabled: full frame and reader start do nothing
      do_reset();
      enable = 1'b0;
      wr_frame();
      rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
      chk_idx("t5_dis", 2'd0, 2'd1, 2'd2);
      check_eq("t5_dis_rep", 32'(repeat_count), 32'h0);
      check_eq("t5_dis_latest", 32'(latest_valid), 32'h0);
      check_eq("t5_dis_err", 32'(wr_seq_err), 32'h0);
      // start while disabled leaves FSM idle; after re-enable done is an error
      wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
      enable = 1'b1;
      wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
      check_eq("t5_reen_err", 32'(wr_seq_err), 32'h1);
      check_eq("t5_reen_w", 32'(wr_idx), 32'h0);
      wr_frame();
      chk_idx("t5_reen_frame", 2'd2, 2'd1, 2'd0);

      // 6. repeat saturation, clear priority, async reset mid-frame
      do_reset();
      rd_frame_start = 1'b1;
      for (int i = 0; i < 70000; i++) @(posedge clk);
      #1;
      check_eq("t6_sat", 32'(repeat_count), 32'h0000_FFFF);
      clear_counts = 1'b1; step();
      clear_counts = 1'b0; rd_frame_start = 1'b0;
      check_eq("t6_clear", 32'(repeat_count), 32'h0);
      wr_frame();
      wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
      check_eq("t6_pre_w", 32'(wr_idx), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk_idx("t6_arst", 2'd0, 2'd1, 2'd2);
      check_eq("t6_arst_wr_base", wr_base, 32'h0000_0000);
      check_eq("t6_arst_rd_base", rd_base, 32'h0040_0000);
      check_eq("t6_arst_latest", 32'(latest_valid), 32'h0);
      check_eq("t6_arst_irq", 32'(irq_new_frame), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
      check_eq("t6_restart_err", 32'(wr_seq_err), 32'h1);
      check_eq("t6_restart_w", 32'(wr_idx), 32'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
